// File: rtl/flash_read_seq_if.sv
// Wishbone slave bus bundle for flash_read_seq: master drives requests, slave returns ack and read data.
interface flash_read_seq_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/flash_read_seq.sv
// Wishbone read sequencer for the 8x8 flash array: precharge -> sense -> select, then capture the byte.
// Optional macro FLASH_RD_IRQ_EN adds irq_o and a CTRL irq-enable bit (bit5).
module flash_read_seq #(
  parameter logic [31:0] BASE_ADR      = 32'h3000_0000,
  parameter int unsigned PRE_CYCLES    = 4,
  parameter int unsigned SENSE_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  flash_read_seq_if.slave wb,
  output logic            sen1_o,
  output logic            sen2_o,
  output logic [3:0]      out_en_o,
  input  logic [7:0]      sense_data_i
`ifdef FLASH_RD_IRQ_EN
  ,
  output logic            irq_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_SENSE = 2'd2,
    ST_SEL   = 2'd3
  } state_e;

  localparam logic [7:0] PRE_LOAD    = 8'(PRE_CYCLES - 1);
  localparam logic [7:0] SENSE_LOAD  = 8'(SENSE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        sen1_q, sen1_d, sen2_q, sen2_d;
  logic [3:0]  out_en_q, out_en_d;

  logic        ack_q, we_q, sel0_q;
  logic [1:0]  reg_q;
  logic [5:0]  wdat_q;
  logic [31:0] rdat_q, rdata_s;

  logic [1:0]  group_q;
  logic        done_q, ovr_q;
  logic [7:0]  data_q;
  logic        irq_en_s;

  logic hit_s, req_s, busy_s, ctrl_wr_s, start_s, accept_s, ovr_set_s, data_rd_s, done_set_s;
  logic unused_s;

  assign hit_s      = (wb.wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign req_s      = wb.wbs_stb_i & wb.wbs_cyc_i & hit_s & ~ack_q;
  assign busy_s     = (state_q != ST_IDLE);
  // Side effects act on the request latched at the request edge, applied at the ack edge.
  assign ctrl_wr_s  = ack_q & we_q & sel0_q & (reg_q == 2'd0);
  assign start_s    = ctrl_wr_s & wdat_q[0];
  assign accept_s   = start_s & ~busy_s;
  assign ovr_set_s  = start_s & busy_s;
  assign data_rd_s  = ack_q & ~we_q & (reg_q == 2'd1);
  assign done_set_s = (state_q == ST_SEL) && (cnt_q == 8'd0);
  assign unused_s   = ^{wb.wbs_adr_i[1:0], wb.wbs_sel_i[3:1], wb.wbs_dat_i[31:6], wdat_q[5]};

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = rdat_q;
  assign sen1_o       = sen1_q;
  assign sen2_o       = sen2_q;
  assign out_en_o     = out_en_q;

  // Register read mux, sampled at the request edge
  always_comb begin
    rdata_s = 32'd0;
    case (wb.wbs_adr_i[3:2])
      2'd0:    rdata_s = {26'd0, irq_en_s, group_q, ovr_q, done_q, busy_s};
      2'd1:    rdata_s = {24'd0, data_q};
      default: rdata_s = 32'd0;
    endcase
  end

  // Bus front end: one-cycle ack, latched request fields, read data only during a read ack
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      we_q   <= 1'b0;
      sel0_q <= 1'b0;
      reg_q  <= 2'd0;
      wdat_q <= 6'd0;
      rdat_q <= 32'd0;
    end else begin
      ack_q  <= req_s;
      we_q   <= wb.wbs_we_i;
      sel0_q <= wb.wbs_sel_i[0];
      reg_q  <= wb.wbs_adr_i[3:2];
      wdat_q <= wb.wbs_dat_i[5:0];
      rdat_q <= (req_s && !wb.wbs_we_i) ? rdata_s : 32'd0;
    end
  end

  // Sequencer state, counter and registered array pins
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      sen1_q   <= 1'b0;
      sen2_q   <= 1'b0;
      out_en_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sen1_q   <= sen1_d;
      sen2_q   <= sen2_d;
      out_en_q <= out_en_d;
    end
  end

  // Next state: each phase reloads the down-counter on entry and leaves when it hits zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_PRE;
          cnt_d   = PRE_LOAD;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      end
      ST_PRE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_SENSE;
          cnt_d   = SENSE_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SENSE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_SEL;
          cnt_d   = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SEL: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Pin values decoded from the next state so the registered pins line up with the state register
  always_comb begin
    sen1_d   = 1'b0;
    sen2_d   = 1'b0;
    out_en_d = 4'd0;
    case (state_d)
      ST_PRE:   sen1_d = 1'b1;
      ST_SENSE: begin
        sen1_d = 1'b1;
        sen2_d = 1'b1;
      end
      ST_SEL: begin
        sen2_d   = 1'b1;
        out_en_d = 4'b0001 << group_q;
      end
      default: begin
        sen1_d   = 1'b0;
        sen2_d   = 1'b0;
        out_en_d = 4'd0;
      end
    endcase
  end

  // Status registers; the done set takes priority over a same-edge DATA read clear
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      group_q <= 2'd0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      data_q  <= 8'd0;
    end else begin
      if (accept_s) group_q <= wdat_q[2:1];
      if (done_set_s) done_q <= 1'b1;
      else if (accept_s || data_rd_s) done_q <= 1'b0;
      if (accept_s) ovr_q <= 1'b0;
      else if (ovr_set_s) ovr_q <= 1'b1;
      if (done_set_s) data_q <= sense_data_i;
    end
  end

`ifdef FLASH_RD_IRQ_EN
  logic irq_en_q, irq_q;

  // Completion interrupt: one pulse when done rises, gated by the enable bit
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr_s) irq_en_q <= wdat_q[5];
      irq_q <= done_set_s & irq_en_q;
    end
  end

  assign irq_en_s = irq_en_q;
  assign irq_o    = irq_q;
`else
  assign irq_en_s = 1'b0;
`endif

endmodule
